// File: rtl/fc_sched_pkg.sv
// Shared definitions for the LeNet-5 fully-connected stage sequencer and
// the neighbouring datapath (layer indices and per-layer output sizes).
package fc_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_GAP    = 2'd2,
      S_FINISH = 2'd3
   } fc_state_e;

   localparam int GAP_CYCLES = 2;

   localparam logic [1:0] FC1 = 2'd0;
   localparam logic [1:0] FC2 = 2'd1;
   localparam logic [1:0] FC3 = 2'd2;

   localparam int FC1_OUT_SIZE = 120;
   localparam int FC2_OUT_SIZE = 84;
   localparam int FC3_OUT_SIZE = 10;

endpackage

// File: rtl/fc_next_layer.sv
// Combinational priority finder: lowest mask bit strictly above cur.
// cur = -1 selects the first set bit of the whole mask.
module fc_next_layer
   import fc_sched_pkg::*;
#(
   parameter int NUM_LAYERS = 3
) (
   input  logic [NUM_LAYERS-1:0] mask,
   input  logic signed [2:0]     cur,
   output logic [1:0]            next,
   output logic                  valid
);

   always_comb begin
      next  = '0;
      valid = 1'b0;
      // Scan downward so the lowest qualifying index is the one left standing.
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(cur))) begin
            next  = 2'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fc_layer_scheduler.sv
// Sequences the FC1/FC2/FC3 engines from one start request, with an
// enable-low gap between layers and a per-layer cycle budget.
module fc_layer_scheduler #(
   parameter int NUM_LAYERS     = 3,
   parameter int TIMEOUT_W      = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int GAP_CYCLES     = fc_sched_pkg::GAP_CYCLES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [NUM_LAYERS-1:0]       layer_mask,
   output logic [NUM_LAYERS-1:0]       fc_en,
   input  logic [NUM_LAYERS-1:0]       fc_done,
   output logic [1:0]                  active_layer,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [TIMEOUT_W-1:0]        layer_cycles,
   output fc_sched_pkg::fc_state_e     fsm_state
);

   import fc_sched_pkg::*;

   // Handshake: fc_en[i] is a level request held until fc_done[i] is seen
   // high at a clock edge; the engine then sees fc_en low for GAP_CYCLES.

   fc_state_e               state, state_n;
   logic [NUM_LAYERS-1:0]   mask_q;
   logic [TIMEOUT_W-1:0]    cnt, cnt_inc;
   logic [7:0]              gap_cnt;
   logic                    aborted;

   logic [NUM_LAYERS-1:0]   find_mask;
   logic signed [2:0]       find_cur;
   logic [1:0]              next_idx;
   logic                    next_vld;

   logic                    done_hit, timeout_hit, gap_last;

   assign find_mask = (state == S_IDLE) ? layer_mask : mask_q;
   assign find_cur  = (state == S_IDLE) ? 3'sb111 : $signed({1'b0, active_layer});

   fc_next_layer #(.NUM_LAYERS(NUM_LAYERS)) u_next (
      .mask  (find_mask),
      .cur   (find_cur),
      .next  (next_idx),
      .valid (next_vld)
   );

   // cnt holds the zero-based RUN cycle; cnt_inc is the number of RUN cycles
   // including the current one, which is what layer_cycles reports.
   assign cnt_inc     = (&cnt) ? cnt : cnt + TIMEOUT_W'(1);
   assign done_hit    = (state == S_RUN) && fc_done[active_layer];
   assign timeout_hit = (state == S_RUN) && !done_hit &&
                        (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   assign gap_last    = (state == S_GAP) && (gap_cnt == 8'(GAP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (start) state_n = next_vld ? S_RUN : S_FINISH;
         S_RUN:    if (done_hit || timeout_hit) state_n = S_GAP;
         S_GAP:    if (gap_last) state_n = (!aborted && next_vld) ? S_RUN : S_FINISH;
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end

   always_comb begin
      fc_en = '0;
      if (state == S_RUN) fc_en[active_layer] = 1'b1;
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FINISH);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q       <= '0;
         active_layer <= '0;
         cnt          <= '0;
         gap_cnt      <= '0;
         aborted      <= 1'b0;
         error        <= 1'b0;
         layer_cycles <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mask_q  <= layer_mask;
                  error   <= 1'b0;
                  aborted <= 1'b0;
                  cnt     <= '0;
                  if (next_vld) active_layer <= next_idx;
               end
            end
            S_RUN: begin
               if (done_hit || timeout_hit) begin
                  layer_cycles <= cnt_inc;
                  gap_cnt      <= '0;
                  if (timeout_hit) begin
                     error   <= 1'b1;
                     aborted <= 1'b1;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt + 8'd1;
               if (gap_last && !aborted && next_vld) begin
                  active_layer <= next_idx;
                  cnt          <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_scheduler.sv
// Directed bench for fc_layer_scheduler: table of whole-run scenarios with
// modelled engines, plus hand-written reset sequences.
module tb_fc_layer_scheduler;
   import fc_sched_pkg::*;

   localparam int TMO = 100;
   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  layer_mask = 3'b000;
   logic [2:0]  fc_en;
   logic [2:0]  fc_done;
   logic [1:0]  active_layer;
   logic        busy, done, error;
   logic [15:0] layer_cycles;
   fc_state_e   fsm_state;

   fc_layer_scheduler #(
      .NUM_LAYERS(3), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .layer_mask(layer_mask),
      .fc_en(fc_en), .fc_done(fc_done), .active_layer(active_layer),
      .busy(busy), .done(done), .error(error), .layer_cycles(layer_cycles),
      .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Engine model: done after eng_len enabled cycles unless hung.
   int         eng_len[3];
   int         ecnt[3];
   logic [2:0] hang = 3'b000;
   logic [2:0] spur = 3'b000;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) ecnt[i] <= fc_en[i] ? ecnt[i] + 1 : 0;
   end

   always_comb begin
      fc_done = 3'b000;
      for (int i = 0; i < 3; i++)
         fc_done[i] = spur[i] | (fc_en[i] && !hang[i] && (ecnt[i] == eng_len[i] - 1));
   end

   // Scoreboard: expected layer order and expected RUN lengths.
   logic [1:0]  exp_q[$];
   logic [15:0] cyc_q[$];
   logic [2:0]  prev_en = 3'b000;
   logic [1:0]  cur_exp = 2'd0;
   int          low_cnt, run_len, runs, done_cnt;
   bit          seen_fall, mon_on;

   always @(negedge clk) begin
      if (mon_on) begin
         if (fc_en != 3'b000) begin
            if (prev_en == 3'b000) begin
               runs++;
               run_len = 0;
               if (seen_fall) chk("gap_len", low_cnt, GAP);
               if (exp_q.size() == 0) chk("extra_run", fc_en, 0);
               else begin
                  cur_exp = exp_q.pop_front();
                  chk("layer_order", active_layer, cur_exp);
               end
            end
            chk("en_onehot", fc_en, 3'b001 << cur_exp);
            run_len++;
         end else begin
            if (prev_en != 3'b000) begin
               chk("cycles_vs_len", layer_cycles, run_len);
               if (cyc_q.size() == 0) chk("extra_cycles", layer_cycles, 0);
               else chk("layer_cycles", layer_cycles, cyc_q.pop_front());
               seen_fall = 1'b1;
               low_cnt   = 0;
            end
            low_cnt++;
         end
         if (done) done_cnt++;
      end
      prev_en = fc_en;
   end

   typedef struct {
      logic [2:0] mask;
      logic [2:0] hang;
      bit         spurious;
      int         n;
      int         layers[3];
      int         cyc[3];
      bit         err;
   } vec_t;

   vec_t vecs[6];

   task automatic set_vec(input int i, input logic [2:0] m, input logic [2:0] h,
                          input bit s, input int n, input int l0, input int l1,
                          input int l2, input int c0, input int c1, input int c2,
                          input bit e);
      vecs[i].mask = m;  vecs[i].hang = h;  vecs[i].spurious = s;  vecs[i].n = n;
      vecs[i].layers[0] = l0;  vecs[i].layers[1] = l1;  vecs[i].layers[2] = l2;
      vecs[i].cyc[0] = c0;  vecs[i].cyc[1] = c1;  vecs[i].cyc[2] = c2;
      vecs[i].err = e;
   endtask

   task automatic run_vec(input int v);
      int lat;
      int lat_exp;
      exp_q.delete();
      cyc_q.delete();
      lat_exp = 1 + GAP * vecs[v].n;
      for (int k = 0; k < vecs[v].n; k++) begin
         exp_q.push_back(2'(vecs[v].layers[k]));
         cyc_q.push_back(16'(vecs[v].cyc[k]));
         lat_exp += vecs[v].cyc[k];
      end
      seen_fall = 1'b0;  runs = 0;  done_cnt = 0;  low_cnt = 0;
      hang   = vecs[v].hang;
      mon_on = 1'b1;
      @(negedge clk);
      start = 1'b1;
      layer_mask = vecs[v].mask;
      @(negedge clk);
      start = 1'b0;
      layer_mask = 3'b000;
      lat = 1;
      chk("busy_after_start", busy, 1);
      chk("error_cleared", error, 0);
      while (!done && lat < 3000) begin
         if (vecs[v].spurious && lat == 10) begin
            spur = 3'b100;
            start = 1'b1;
            layer_mask = 3'b111;
         end
         @(negedge clk);
         lat++;
         spur = 3'b000;
         start = 1'b0;
         layer_mask = 3'b000;
      end
      chk("done_latency", lat, lat_exp);
      chk("busy_with_done", busy, 1);
      chk("error_at_done", error, vecs[v].err);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      repeat (5) @(negedge clk);
      chk("run_count", runs, vecs[v].n);
      chk("done_pulses", done_cnt, 1);
      chk("layers_left", exp_q.size(), 0);
      chk("fc_en_idle", fc_en, 0);
      chk("state_idle", fsm_state, S_IDLE);
      mon_on = 1'b0;
   endtask

   initial begin
      int w;
      eng_len[0] = 50;  eng_len[1] = 30;  eng_len[2] = 20;
      set_vec(0, 3'b111, 3'b000, 0, 3, 0, 1, 2, 50, 30,  20, 0);
      set_vec(1, 3'b101, 3'b000, 0, 2, 0, 2, 0, 50, 20,   0, 0);
      set_vec(2, 3'b111, 3'b010, 0, 2, 0, 1, 0, 50, TMO,  0, 1);
      set_vec(3, 3'b001, 3'b000, 0, 1, 0, 0, 0, 50, 0,    0, 0);
      set_vec(4, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0,  0,    0, 0);
      set_vec(5, 3'b001, 3'b000, 1, 1, 0, 0, 0, 50, 0,    0, 0);

      repeat (3) @(negedge clk);
      chk("rst_fc_en", fc_en, 0);
      chk("rst_active_layer", active_layer, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_layer_cycles", layer_cycles, 0);
      chk("rst_state", fsm_state, S_IDLE);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 6; v++) run_vec(v);

      // Reset asserted while FC2 is running.
      hang = 3'b000;
      start = 1'b1;
      layer_mask = 3'b111;
      @(negedge clk);
      start = 1'b0;
      layer_mask = 3'b000;
      w = 0;
      while (fc_en != 3'b010 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("reach_fc2", fc_en, 3'b010);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_fc_en", fc_en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_active_layer", active_layer, 0);
      chk("midrst_layer_cycles", layer_cycles, 0);
      chk("midrst_state", fsm_state, S_IDLE);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_stays_idle", fsm_state, S_IDLE);
      run_vec(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
